// File: rtl/blackjack_controller_pkg.sv
// Shared types and constants for the blackjack round sequencer:
// command and state encodings, result codes and card legality.
package blackjack_controller_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_HIT   = 2'd1,
        CMD_STAND = 2'd2
    } game_command_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEAL_P1,
        S_DEAL_D1,
        S_DEAL_P2,
        S_DEAL_D2,
        S_PLAYER_TURN,
        S_PLAYER_HIT,
        S_DEALER_TURN,
        S_DEALER_HIT,
        S_RESULT
    } state_t;

    localparam logic [1:0] RESULT_NONE   = 2'd0;
    localparam logic [1:0] RESULT_PLAYER = 2'd1;
    localparam logic [1:0] RESULT_DEALER = 2'd2;
    localparam logic [1:0] RESULT_PUSH   = 2'd3;

    localparam logic [4:0] BUST_LIMIT = 5'd21;
    localparam logic [4:0] ACE_BONUS  = 5'd10;

    // Ranks 1..13 are real cards; 0, 14 and 15 come from a faulty source.
    function automatic logic card_legal(input logic [3:0] value);
        return (value != 4'd0) && (value <= 4'd13);
    endfunction

endpackage

// File: rtl/blackjack_controller_if.sv
// Command, card-source and display signals of the blackjack controller.
// The slave modport is the controller; master is the surrounding system.
interface blackjack_controller_if;

    logic                                  i_start;
    logic                                  i_ready;
    blackjack_controller_pkg::game_command_t i_command;
    logic                                  o_turnIndicator;
    logic                                  o_card_req;
    logic                                  i_card_valid;
    logic [3:0]                            i_card_value;
    logic [4:0]                            o_player_total;
    logic [4:0]                            o_dealer_total;
    logic [1:0]                            o_result;
    logic                                  o_game_over;
    logic                                  o_error;

    modport master (
        output i_start, i_ready, i_command, i_card_valid, i_card_value,
        input  o_turnIndicator, o_card_req, o_player_total, o_dealer_total,
               o_result, o_game_over, o_error
    );

    modport slave (
        input  i_start, i_ready, i_command, i_card_valid, i_card_value,
        output o_turnIndicator, o_card_req, o_player_total, o_dealer_total,
               o_result, o_game_over, o_error
    );

endinterface

// File: rtl/blackjack_controller_hand_accumulator.sv
// One blackjack hand: hard sum with aces as 1 plus an ace flag.
// bust looks ahead through a card being added this cycle, so callers can branch on the same edge.
module hand_accumulator
    import blackjack_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       add,
    input  logic [3:0] card_value,
    output logic [4:0] hard,
    output logic       ace,
    output logic [4:0] effective,
    output logic       bust
);

    logic [4:0] hard_reg;
    logic       ace_reg;
    logic [4:0] points;
    logic [4:0] hard_next;

    always_comb begin
        points = 5'd0;
        if (card_value >= 4'd11 && card_value <= 4'd13) begin
            points = 5'd10;
        end else if (card_value != 4'd0 && card_value <= 4'd10) begin
            points = {1'b0, card_value};
        end
    end

    assign hard_next = hard_reg + (add ? points : 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hard_reg <= 5'd0;
            ace_reg  <= 1'b0;
        end else if (clear) begin
            hard_reg <= 5'd0;
            ace_reg  <= 1'b0;
        end else if (add) begin
            hard_reg <= hard_next;
            if (card_value == 4'd1) begin
                ace_reg <= 1'b1;
            end
        end
    end

    assign hard      = hard_reg;
    assign ace       = ace_reg;
    assign effective = (ace_reg && hard_reg <= (BUST_LIMIT - ACE_BONUS)) ? hard_reg + ACE_BONUS
                                                                         : hard_reg;
    assign bust      = hard_next > BUST_LIMIT;

endmodule

// File: rtl/blackjack_controller.sv
// Single-round blackjack sequencer: opening deal, player HIT/STAND turn,
// dealer draw-out and result posting.
module blackjack_controller
    import blackjack_controller_pkg::*;
#(
    parameter int DEALER_STAND      = 17,
    parameter bit DEALER_HIT_SOFT17 = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    blackjack_controller_if.slave bus
);

    state_t     state_reg, state_next;
    logic [1:0] result_reg, result_next;
    logic       lock_reg;
    logic       error_reg;

    logic       card_req, card_ok, take_card, start_round, act;
    logic       player_add, dealer_add, player_21, dealer_draw;
    logic [4:0] p_hard, p_eff, d_hard, d_eff;
    logic       p_ace, p_bust, d_ace, d_bust;

    assign card_req    = state_reg inside {S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2,
                                           S_PLAYER_HIT, S_DEALER_HIT};
    assign card_ok     = card_legal(bus.i_card_value);
    assign take_card   = card_req && bus.i_card_valid && card_ok;
    assign start_round = bus.i_start && (state_reg == S_IDLE || state_reg == S_RESULT);
    assign player_add  = take_card && (state_reg inside {S_DEAL_P1, S_DEAL_P2, S_PLAYER_HIT});
    assign dealer_add  = take_card && (state_reg inside {S_DEAL_D1, S_DEAL_D2, S_DEALER_HIT});

    assign player_21   = (p_hard == BUST_LIMIT) || (p_ace && p_hard == (BUST_LIMIT - ACE_BONUS));
    assign dealer_draw = (int'(d_eff) < DEALER_STAND) ||
                         (DEALER_HIT_SOFT17 && d_ace && d_hard == 5'd7);
    // A natural or drawn-to 21 ends the player's turn, so it never counts as a press.
    assign act         = (state_reg == S_PLAYER_TURN) && bus.i_ready && !lock_reg && !player_21 &&
                         (bus.i_command == CMD_HIT || bus.i_command == CMD_STAND);

    hand_accumulator u_player (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .clear     (start_round),
        .add       (player_add),
        .card_value(bus.i_card_value),
        .hard      (p_hard),
        .ace       (p_ace),
        .effective (p_eff),
        .bust      (p_bust)
    );

    hand_accumulator u_dealer (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .clear     (start_round),
        .add       (dealer_add),
        .card_value(bus.i_card_value),
        .hard      (d_hard),
        .ace       (d_ace),
        .effective (d_eff),
        .bust      (d_bust)
    );

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        case (state_reg)
            S_IDLE, S_RESULT: if (bus.i_start) state_next = S_DEAL_P1;
            S_DEAL_P1:        if (take_card) state_next = S_DEAL_D1;
            S_DEAL_D1:        if (take_card) state_next = S_DEAL_P2;
            S_DEAL_P2:        if (take_card) state_next = S_DEAL_D2;
            S_DEAL_D2:        if (take_card) state_next = S_PLAYER_TURN;
            S_PLAYER_TURN: begin
                if (player_21) begin
                    state_next = S_DEALER_TURN;
                end else if (act) begin
                    state_next = (bus.i_command == CMD_HIT) ? S_PLAYER_HIT : S_DEALER_TURN;
                end
            end
            S_PLAYER_HIT: begin
                if (take_card) begin
                    if (p_bust) begin
                        state_next  = S_RESULT;
                        result_next = RESULT_DEALER;
                    end else begin
                        state_next  = S_PLAYER_TURN;
                    end
                end
            end
            S_DEALER_TURN: begin
                if (dealer_draw) begin
                    state_next = S_DEALER_HIT;
                end else begin
                    state_next = S_RESULT;
                    if (d_bust || p_eff > d_eff) result_next = RESULT_PLAYER;
                    else if (p_eff < d_eff)      result_next = RESULT_DEALER;
                    else                         result_next = RESULT_PUSH;
                end
            end
            S_DEALER_HIT:     if (take_card) state_next = S_DEALER_TURN;
            default:          state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg  <= S_IDLE;
            result_reg <= RESULT_NONE;
            lock_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            error_reg <= card_req && bus.i_card_valid && !card_ok;
            if (start_round) begin
                result_reg <= RESULT_NONE;
                lock_reg   <= 1'b0;
            end else begin
                result_reg <= result_next;
                if (act) begin
                    lock_reg <= 1'b1;
                end else if (bus.i_command == CMD_NONE) begin
                    lock_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.o_turnIndicator = (state_reg == S_PLAYER_TURN);
    assign bus.o_card_req      = card_req;
    assign bus.o_player_total  = p_eff;
    assign bus.o_dealer_total  = d_eff;
    assign bus.o_result        = result_reg;
    assign bus.o_game_over     = (state_reg == S_RESULT);
    assign bus.o_error         = error_reg;

endmodule

// File: tb/tb_blackjack_controller.sv
// Directed and randomized rounds of the blackjack controller checked against a
// card-counting model of the game rules; a second instance covers dealer soft-17 hits.
module tb_blackjack_controller;
    import blackjack_controller_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic          card_valid = 1'b0;
    logic [3:0]    card_value = 4'd0;
    game_command_t command = CMD_NONE;

    always #5 clk = ~clk;

    blackjack_controller_if bif ();
    blackjack_controller_if bif17 ();

    assign bif.i_start        = start;
    assign bif.i_ready        = ready;
    assign bif.i_command      = command;
    assign bif.i_card_valid   = card_valid;
    assign bif.i_card_value   = card_value;
    assign bif17.i_start      = start;
    assign bif17.i_ready      = ready;
    assign bif17.i_command    = command;
    assign bif17.i_card_valid = card_valid;
    assign bif17.i_card_value = card_value;

    blackjack_controller dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .bus      (bif)
    );

    blackjack_controller #(.DEALER_STAND(17), .DEALER_HIT_SOFT17(1'b1)) dut_s17 (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .bus      (bif17)
    );

    int vectors = 0;
    int miscompares = 0;
    int p_hard, d_hard;
    bit p_ace, d_ace;
    int deck[$];
    int taken;

    function automatic int points(input int v);
        return (v >= 10) ? 10 : v;
    endfunction

    // Best blackjack value: one ace may count 11 when that does not exceed 21.
    function automatic int best(input int hard, input bit ace);
        return (ace && hard + 10 <= 21) ? hard + 10 : hard;
    endfunction

    function automatic int expected_result();
        if (p_hard > 21) return 2;
        if (d_hard > 21) return 1;
        if (best(p_hard, p_ace) > best(d_hard, d_ace)) return 1;
        if (best(p_hard, p_ace) < best(d_hard, d_ace)) return 2;
        return 3;
    endfunction

    function automatic int draw();
        if (deck.size() > 0) return deck.pop_front();
        return int'($urandom_range(1, 13));
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_card(input int v);
        int n = 0;
        while (!bif.o_card_req && n < 40) begin
            tick();
            n++;
        end
        check("card_req_wait", bif.o_card_req, 1);
        card_valid = 1'b1;
        card_value = 4'(v);
        tick();
        card_valid = 1'b0;
        card_value = 4'd0;
    endtask

    task automatic deal_card(input bit to_player, input int v);
        serve_card(v);
        if (to_player) begin
            p_hard += points(v);
            if (v == 1) p_ace = 1'b1;
        end else begin
            d_hard += points(v);
            if (v == 1) d_ace = 1'b1;
        end
        check("player_total", bif.o_player_total, best(p_hard, p_ace));
        check("dealer_total", bif.o_dealer_total, best(d_hard, d_ace));
    endtask

    task automatic start_round();
        p_hard = 0; d_hard = 0; p_ace = 1'b0; d_ace = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_game_over", bif.o_game_over, 0);
        check("start_result", bif.o_result, 0);
        check("start_totals", {bif.o_player_total, bif.o_dealer_total}, 0);
        check("start_card_req", bif.o_card_req, 1);
    endtask

    task automatic deal4();
        for (int i = 0; i < 4; i++) deal_card(i % 2 == 0, draw());
        check("turn_after_deal", bif.o_turnIndicator, 1);
    endtask

    task automatic player_phase(input int stand_at);
        if (best(p_hard, p_ace) == 21) return;
        while (best(p_hard, p_ace) < stand_at) begin
            ready = 1'b1; command = CMD_HIT;
            tick();
            ready = 1'b0; command = CMD_NONE;
            deal_card(1'b1, draw());
            if (p_hard > 21 || best(p_hard, p_ace) == 21) return;
            check("turn_after_hit", bif.o_turnIndicator, 1);
        end
        ready = 1'b1; command = CMD_STAND;
        tick();
        ready = 1'b0; command = CMD_NONE;
        check("turn_after_stand", bif.o_turnIndicator, 0);
    endtask

    task automatic dealer_phase();
        if (p_hard > 21) return;
        while (best(d_hard, d_ace) < 17) deal_card(1'b0, draw());
    endtask

    task automatic finish_check(input string tag);
        int n = 0;
        while (!bif.o_game_over && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_game_over"}, bif.o_game_over, 1);
        check({tag, "_result"}, bif.o_result, expected_result());
        check({tag, "_player"}, bif.o_player_total, best(p_hard, p_ace));
        check({tag, "_dealer"}, bif.o_dealer_total, best(d_hard, d_ace));
        check({tag, "_no_req"}, bif.o_card_req, 0);
        $display("round %s: player %0d dealer %0d result %0d", tag,
                 best(p_hard, p_ace), best(d_hard, d_ace), bif.o_result);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bif.o_turnIndicator, bif.o_card_req, bif.o_player_total,
                                bif.o_dealer_total, bif.o_result, bif.o_game_over, bif.o_error}, 0);
        reset_n = 1'b1;
        tick();
        check("idle_no_req", bif.o_card_req, 0);

        // Dealer 15 draws to 20 and beats the player's 19.
        deck = '{10, 7, 9, 8, 5};
        start_round(); deal4(); player_phase(17); dealer_phase(); finish_check("stand19");
        check("stand19_const", {bif.o_result, bif.o_dealer_total}, {2'd2, 5'd20});

        // Two-card 21 plays on without a command; dealer 16 draws 2.
        deck = '{1, 6, 10, 10, 2};
        start_round(); deal4(); player_phase(17); dealer_phase(); finish_check("natural");
        check("natural_const", bif.o_result, 1);

        // HIT held for 20 cycles must take exactly one card.
        deck = '{10, 10, 6, 7};
        start_round(); deal4();
        ready = 1'b1; command = CMD_HIT; card_valid = 1'b1; card_value = 4'd9; taken = 0;
        repeat (20) begin
            if (bif.o_card_req) taken++;
            tick();
        end
        ready = 1'b0; command = CMD_NONE; card_valid = 1'b0; card_value = 4'd0;
        p_hard += 9;
        check("held_hit_cards", taken, 1);
        finish_check("held_hit");
        check("held_hit_hard", {bif.o_result, bif.o_player_total}, {2'd2, 5'd25});

        // Dealer soft 17: standard instance stands, soft-17 instance draws.
        deck = '{10, 1, 9, 6};
        start_round(); deal4(); player_phase(17);
        tick();
        check("soft17_stand", {bif.o_game_over, bif.o_card_req}, 2'b10);
        check("soft17_hit_req", bif17.o_card_req, 1);
        dealer_phase(); finish_check("soft17");
        card_valid = 1'b1; card_value = 4'd3;
        tick();
        card_valid = 1'b0; card_value = 4'd0;
        repeat (3) tick();
        check("soft17_hit_result", {bif17.o_game_over, bif17.o_result, bif17.o_dealer_total},
              {1'b1, 2'd2, 5'd20});

        // Reset while the dealer waits for a card abandons the round.
        deck = '{10, 6, 10, 5};
        start_round(); deal4(); player_phase(17);
        n = 0;
        while (!bif.o_card_req && n < 20) begin
            tick();
            n++;
        end
        check("dealer_hit_req", bif.o_card_req, 1);
        reset_n = 1'b0;
        #1;
        check("midround_reset", {bif.o_turnIndicator, bif.o_card_req, bif.o_player_total,
                                 bif.o_dealer_total, bif.o_result, bif.o_game_over, bif.o_error}, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("after_reset_idle", {bif.o_card_req, bif.o_game_over, bif17.o_card_req}, 0);

        // Illegal rank 14 is refused with an error pulse; 12 then counts as 10. Ends in a push.
        start_round();
        deal_card(1'b1, 9);
        card_valid = 1'b1; card_value = 4'd14;
        tick();
        check("illegal_error", {bif.o_error, bif.o_card_req}, 2'b11);
        check("illegal_not_taken", bif.o_dealer_total, 0);
        card_value = 4'd12;
        tick();
        card_valid = 1'b0; card_value = 4'd0;
        d_hard += 10;
        check("legal_after_error", {bif.o_error, bif.o_dealer_total}, {1'b0, 5'd10});
        deal_card(1'b1, 9); deal_card(1'b0, 8);
        player_phase(17); dealer_phase(); finish_check("push");
        check("push_const", bif.o_result, 3);

        for (int r = 0; r < 30; r++) begin
            deck.delete();
            start_round(); deal4();
            player_phase(int'($urandom_range(12, 20)));
            dealer_phase();
            finish_check($sformatf("random%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule

// File: doc/blackjack_controller.md
Name: blackjack_controller

Overview:
- Central game sequencer for one round of single-player blackjack.
- Deals the four opening cards, grants the player turn and consumes HIT/STAND commands from the user-input block, then plays the dealer hand and posts the result.
- Sits between the user-input block (commands), a card source (shuffled deck/RNG, request/valid handshake) and the display logic (totals, result).

Parameters:
- DEALER_STAND, 17, dealer stops drawing when its effective total is >= this value.
- DEALER_HIT_SOFT17, 0, when 1 the dealer draws on a soft 17 (effective 17 with an ace counted as 11).

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- i_start  input  1  single-cycle pulse; begins a new round from IDLE or RESULT
- i_ready  input  1  user-input block reports a button press on the player's turn
- i_command  input  `gameCommand  NONE/HIT/STAND from the user-input block
- o_turnIndicator  output  1  high only in PLAYER_TURN
- o_card_req  output  1  request for the next card
- i_card_valid  input  1  card source presents a card
- i_card_value  input  4  rank 1..13; 1 = ace, 11..13 count as 10
- o_player_total  output  5  effective player total
- o_dealer_total  output  5  effective dealer total
- o_result  output  2  0 none, 1 player win, 2 dealer win, 3 push
- o_game_over  output  1  high in RESULT
- o_error  output  1  one-cycle pulse on an illegal card value

Behaviour:
- Reset (async, i_reset_n = 0): state IDLE; all outputs 0; hand registers and press lock cleared. Reset mid-round abandons the round with no result.
- States: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_TURN, PLAYER_HIT, DEALER_TURN, DEALER_HIT, RESULT.
- Start and deal:
  - IDLE or RESULT with i_start goes to DEAL_P1 next cycle. Hands, result and lock are cleared on that edge.
  - i_start is ignored in every other state.
- Card handshake:
  - o_card_req is high in DEAL_*, PLAYER_HIT and DEALER_HIT (Moore, registered state).
  - A card is consumed on the edge where o_card_req && i_card_valid; the state advances on that same edge.
  - Values 0, 14 and 15 are illegal: not consumed, o_error pulses, and o_card_req stays high.
- Hand arithmetic:
  - Each hand holds a hard sum (ace = 1, 5 bits) and an ace flag.
  - effective = hard + 10 if the ace flag is set and hard <= 11; otherwise effective = hard.
  - Maximum hard sum is 30, so 5 bits never wrap.
- Deal order: DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> PLAYER_TURN.
- PLAYER_TURN:
  - A command is acted on only when i_ready = 1 and the lock is clear; acting sets the lock.
  - The lock clears on any cycle with i_command == NONE, so a held button yields exactly one action.
  - HIT goes to PLAYER_HIT. STAND goes to DEALER_TURN.
  - Effective 21 on entry (including two-card 21) auto-advances to DEALER_TURN with no command needed.
- PLAYER_HIT: after the card is consumed, hard > 21 -> RESULT with result 2 (dealer turn skipped); otherwise back to PLAYER_TURN.
- DEALER_TURN, evaluated one cycle after entry:
  - Draw when effective < DEALER_STAND.
  - Also draw when DEALER_HIT_SOFT17 = 1 and the hand is soft 17.
  - Drawing goes to DEALER_HIT, which returns to DEALER_TURN after the card is consumed.
  - Otherwise go to RESULT.
- Result, registered on entry to RESULT:
  - Dealer hard > 21 -> 1.
  - Otherwise compare effective totals: player higher -> 1, lower -> 2, equal -> 3.
  - o_result and o_game_over hold until the next i_start or reset.
- Simultaneous events: i_card_valid outside request states is ignored. i_ready outside PLAYER_TURN is ignored and does not set the lock.

Decomposition:
- Shared package/header, alongside gameCommand.svh, holds:
  - the state enum;
  - result codes (RESULT_NONE, RESULT_PLAYER, RESULT_DEALER, RESULT_PUSH);
  - BUST_LIMIT = 21 and ACE_BONUS = 10.
- One sub-module, hand_accumulator, instantiated twice (player and dealer):
  - inputs: clear, add, card value;
  - outputs: hard sum, ace flag, effective total, bust;
  - rank -> points mapping lives inside it.

Test Plan:
- Start, cards 10,7,9,8 (P,D,P,D); player STAND -> player 19, dealer 15 draws; card 5 -> dealer 20, result 2, o_game_over = 1.
- Cards 1,6,10,10 -> player effective 21, auto-advance without command; dealer 16 draws 2 -> 18; result 1.
- Player 10,6 + HIT held for 20 cycles with card 9 -> exactly one card drawn, hard 25, result 2, no dealer draw.
- Dealer ace + 6 (soft 17): DEALER_HIT_SOFT17 = 0 -> no draw; DEALER_HIT_SOFT17 = 1 -> o_card_req asserted.
- Card value 14 during DEAL_D1 -> o_error pulse, state held; then value 12 accepted as 10.
- i_reset_n low during DEALER_HIT -> immediately IDLE, all outputs 0; later i_start runs a clean round; player 18 vs dealer 18 -> result 3.
